// File: rtl/game_screen_hold_anim_if.sv
// Pixel-side bus between the OLED driver / screen mux and the hold-tutorial screen.
interface game_screen_hold_anim_if;
  logic [6:0]  x;
  logic [5:0]  y;
  logic        frame_begin;
  logic        btn;
  logic        restart;
  logic [15:0] oled_data;
  logic        done;

  modport master (output x, y, frame_begin, btn, restart, input oled_data, done);
  modport slave  (input x, y, frame_begin, btn, restart, output oled_data, done);
endinterface

// File: rtl/game_screen_hold_anim.sv
// Press-and-hold tutorial screen: blinking prompt, sliding hand sprite,
// progress bar that fills while the button is held, done once complete.
module game_screen_hold_anim #(
  parameter int          BLINK_FRAMES       = 30,
  parameter int          HOLD_FRAMES        = 60,
  parameter int          PRESS_OFFSET       = 2,
  parameter logic [15:0] BG_COLOUR          = 16'h001F,
  parameter logic [15:0] FG_COLOUR          = 16'hFFFF,
  parameter logic [15:0] BAR_COLOUR         = 16'h07E0,
  parameter logic [15:0] BTN_COLOUR         = 16'hF800,
  parameter logic [15:0] BTN_PRESSED_COLOUR = 16'hFFE0
) (
  input  logic                    clk,
  input  logic                    reset,
  game_screen_hold_anim_if.slave  bus
);

  typedef enum logic [1:0] {S_PROMPT, S_HOLD, S_DONE} state_t;

  state_t      r_state, w_state_nxt;
  logic [6:0]  r_hold_cnt, w_hold_nxt;
  logic [7:0]  r_frame_cnt;
  logic        r_blink_on;
  logic        r_btn_q;
  logic [15:0] r_oled;
  logic        r_done;
  logic        w_done_d, w_show_press, w_show_hold;

  // restart acts on any cycle and pre-empts the frame-rate FSM advance
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_PROMPT;
      r_hold_cnt <= '0;
    end else if (bus.restart) begin
      r_state    <= S_PROMPT;
      r_hold_cnt <= '0;
    end else if (bus.frame_begin) begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold_cnt;
    case (r_state)
      S_PROMPT: if (bus.btn) begin
        w_hold_nxt  = 7'd1;
        w_state_nxt = (HOLD_FRAMES == 1) ? S_DONE : S_HOLD;
      end
      S_HOLD: begin
        if (!bus.btn) begin
          w_state_nxt = S_PROMPT;
          w_hold_nxt  = '0;
        end else if (r_hold_cnt == 7'(HOLD_FRAMES - 1)) begin
          w_state_nxt = S_DONE;
          w_hold_nxt  = 7'(HOLD_FRAMES);
        end else begin
          w_hold_nxt  = r_hold_cnt + 7'd1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    w_done_d     = (r_state == S_DONE);
    w_show_press = ((r_state == S_PROMPT) && r_blink_on) || (r_state == S_DONE);
    w_show_hold  = (r_state == S_HOLD) || (r_state == S_DONE);
  end

  // blink and button sample run every frame regardless of state or restart
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frame_cnt <= '0;
      r_blink_on  <= 1'b1;
      r_btn_q     <= 1'b0;
    end else if (bus.frame_begin) begin
      r_btn_q <= bus.btn;
      if (r_frame_cnt == 8'(BLINK_FRAMES - 1)) begin
        r_frame_cnt <= '0;
        r_blink_on  <= ~r_blink_on;
      end else begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
    end
  end

  logic [6:0]  w_x, w_y, w_hoff;
  logic        w_bar_ol, w_bar_fill, w_hand, w_btn, w_press, w_holdtxt;
  logic [15:0] w_pix;

  always_comb begin
    w_x    = bus.x;
    w_y    = {1'b0, bus.y};
    w_hoff = r_btn_q ? 7'(PRESS_OFFSET) : 7'd0;

    w_bar_ol   = (((w_y == 7'd1) || (w_y == 7'd6)) && (w_x >= 7'd2) && (w_x <= 7'd93)) ||
                 (((w_x == 7'd2) || (w_x == 7'd93)) && (w_y >= 7'd1) && (w_y <= 7'd6));
    w_bar_fill = (w_x >= 7'd3) && ({1'b0, w_x} <= (8'd2 + {1'b0, r_hold_cnt})) &&
                 (w_y >= 7'd2) && (w_y <= 7'd5);
    w_hand     = (w_x >= 7'd30) && (w_x <= 7'd60) &&
                 (w_y >= 7'd8 + w_hoff) && (w_y <= 7'd48 + w_hoff) &&
                 ((w_x <= 7'd31) || (w_x >= 7'd59) ||
                  (w_y <= 7'd9 + w_hoff) || (w_y >= 7'd47 + w_hoff));
    w_btn      = (w_x >= 7'd45) && (w_x <= 7'd57) && (w_y >= 7'd55) && (w_y <= 7'd59);
    w_press    = w_show_press && (w_x >= 7'd3) && (w_x <= 7'd26) && (w_y >= 7'd12) && (w_y <= 7'd16);
    w_holdtxt  = w_show_hold && (w_x >= 7'd3) && (w_x <= 7'd21) && (w_y >= 7'd24) && (w_y <= 7'd28);

    w_pix = BG_COLOUR;
    if (w_x > 7'd95)              w_pix = BG_COLOUR;
    else if (w_bar_ol)            w_pix = FG_COLOUR;
    else if (w_bar_fill)          w_pix = BAR_COLOUR;
    else if (w_hand)              w_pix = FG_COLOUR;
    else if (w_btn)               w_pix = r_btn_q ? BTN_PRESSED_COLOUR : BTN_COLOUR;
    else if (w_press | w_holdtxt) w_pix = FG_COLOUR;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_oled <= BG_COLOUR;
      r_done <= 1'b0;
    end else begin
      r_oled <= w_pix;
      r_done <= w_done_d;
    end
  end

  assign bus.oled_data = r_oled;
  assign bus.done      = r_done;

endmodule

// File: doc/game_screen_hold_anim.md
Name: game_screen_hold_anim

Overview:
- Animated successor to the static instruction screens on the 96x64 OLED.
- Draws a press-and-hold tutorial screen with a blinking PRESS prompt and a hand sprite that slides onto the button.
- Shows a progress bar that fills while the centre button is held, and raises done once the hold completes.
- Sits between the OLED driver (pixel index, frame_begin) and the screen mux; colours, timing and offsets are parametrised.

Parameters:
- BLINK_FRAMES, 30: frames per blink half-period of the prompt (1..255).
- HOLD_FRAMES, 60: frames of continuous hold required to complete (1..90).
- PRESS_OFFSET, 2: rows the hand sprite moves down while the button is pressed (0..7).
- BG_COLOUR, 16'h001F: background colour.
- FG_COLOUR, 16'hFFFF: colour of the hand, text blocks and bar outline.
- BAR_COLOUR, 16'h07E0: colour of the progress bar fill.
- BTN_COLOUR, 16'hF800: colour of the button cap when released.
- BTN_PRESSED_COLOUR, 16'hFFE0: colour of the button cap when pressed.

Ports:
- clk  in  1  pixel clock (6.25 MHz domain).
- reset  in  1  asynchronous, active-high reset.
- x  in  7  pixel column, 0..95.
- y  in  6  pixel row, 0..63.
- frame_begin  in  1  one-cycle pulse at the start of each frame.
- btn  in  1  debounced centre-button level (1 = pressed).
- restart  in  1  one-cycle pulse that returns the block to PROMPT.
- oled_data  out  16  registered RGB565 pixel.
- done  out  1  high while in state DONE.

Behaviour:
- One clock; reset is asynchronous and active-high. Every register also clears on reset.
- Reset values:
  - state = PROMPT, hold_cnt = 0, frame_cnt = 0, blink_on = 1, btn_q = 0.
  - oled_data = BG_COLOUR, done = 0.
- Sampling and update rules:
  - btn is sampled into btn_q only on cycles where frame_begin = 1.
  - All state, counter and blink updates happen only on frame_begin cycles, so there is no tearing within a frame.
  - Exception: restart acts on any cycle.
- Blink:
  - frame_cnt increments on each frame_begin.
  - When frame_cnt reaches BLINK_FRAMES-1, it wraps to 0 and blink_on toggles.
  - The blink counter runs in all states.
- FSM, evaluated on frame_begin using the freshly sampled btn:
  - PROMPT: if btn = 1, go to HOLD with hold_cnt = 1.
  - HOLD, btn = 0: go to PROMPT with hold_cnt = 0 (the bar empties).
  - HOLD, btn = 1 and hold_cnt = HOLD_FRAMES-1: hold_cnt becomes HOLD_FRAMES, state becomes DONE.
  - HOLD, btn = 1 otherwise: hold_cnt increments.
  - HOLD_FRAMES = 1: PROMPT goes straight to DONE on the first pressed frame, with hold_cnt = 1.
  - DONE: hold. hold_cnt stays at HOLD_FRAMES and btn is ignored.
- restart:
  - On any cycle, forces state = PROMPT and hold_cnt = 0.
  - Leaves frame_cnt and blink_on untouched.
  - Restart together with frame_begin: restart wins, and no FSM advance occurs that cycle.
- done = (state == DONE), registered, valid one cycle after the state change.
- Pixel pipeline:
  - oled_data is registered: one-cycle latency from x/y.
  - The pixel colour is chosen by priority, highest first: bar, hand, button, text, background.
  - hoff = PRESS_OFFSET if btn_q = 1, else 0.
- Progress bar:
  - Outline in FG_COLOUR: rows y = 1 and y = 6 for x 2..93, plus columns x = 2 and x = 93 for y 1..6.
  - Fill in BAR_COLOUR: x 3..(2+hold_cnt), y 2..5; no fill pixels when hold_cnt = 0.
- Hand, in FG_COLOUR:
  - Two-pixel-thick rectangle outline.
  - Columns x 30..31 and x 59..60.
  - Rows y 8+hoff .. 9+hoff and y 47+hoff .. 48+hoff.
  - Spans x 30..60, y 8+hoff .. 48+hoff.
- Button cap:
  - Filled rectangle x 45..57, y 55..59.
  - BTN_PRESSED_COLOUR when btn_q = 1, else BTN_COLOUR.
- Text blocks, in FG_COLOUR:
  - PRESS block: x 3..26, y 12..16; shown when state = PROMPT and blink_on = 1.
  - HOLD block: x 3..21, y 24..28; shown when state = HOLD, steady.
  - Both blocks are shown steady in DONE.
- Out-of-range coordinates (x > 95) render BG_COLOUR.

Test Plan:
- Reset: assert reset mid-frame → oled_data = 16'h001F and done = 0 immediately; after release, pixel (10,14) reads FG_COLOUR and pixel (0,40) reads BG_COLOUR.
- Blink: btn = 0 for 60 frame_begin pulses → pixel (10,14) shows FG for frames 0..29, BG for frames 30..59, then FG again.
- Hold completes: btn = 1 for 60 frames → done rises one cycle after the 60th frame_begin; pixel (62,3) is BAR_COLOUR; pixel (30,10) is FG (hoff = 2).
- Early release: hold for 20 frames, then release → state PROMPT, pixel (3,3) is BG, done = 0, button pixel (50,57) is 16'hF800.
- Restart race: in DONE, pulse restart on the same cycle as frame_begin with btn = 1 → state PROMPT, hold_cnt = 0; the HOLD transition occurs only on the next frame_begin.
- Latency: sweep x 0..95 at y = 57 with btn_q = 1 → oled_data one cycle later is 16'hFFE0 exactly for x 45..57.
